// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: mode encodings and skid-buffer state encoding shared by the
// imm_ext_pipe block. Revision 1.0.
`default_nettype none

package imm_ext_pkg;

  localparam logic [1:0] MODE_SIGN    = 2'b00;
  localparam logic [1:0] MODE_ZERO    = 2'b01;
  localparam logic [1:0] MODE_UPPER   = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

`default_nettype wire

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational immediate extension (sign / zero / upper-place,
// illegal mode flags an error and yields zero). Revision 1.0.
`default_nettype none

module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm_i,
  input  logic [1:0]       mode_i,
  output logic [OUT_W-1:0] ext_o,
  output logic             err_o
);

  localparam int PAD = OUT_W - IN_W;

  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] zero_ext;
  logic [OUT_W-1:0] upper_ext;

  if (OUT_W < IN_W) begin : g_width_check
    $error("imm_ext_core: OUT_W must be >= IN_W");
  end else if (PAD == 0) begin : g_same
    assign sign_ext  = imm_i;
    assign zero_ext  = imm_i;
    assign upper_ext = imm_i;
  end else begin : g_pad
    assign sign_ext  = {{PAD{imm_i[IN_W-1]}}, imm_i};
    assign zero_ext  = {{PAD{1'b0}}, imm_i};
    assign upper_ext = {imm_i, {PAD{1'b0}}};
  end

  always_comb begin
    ext_o = '0;
    err_o = 1'b0;
    case (mode_i)
      MODE_SIGN:    ext_o = sign_ext;
      MODE_ZERO:    ext_o = zero_ext;
      MODE_UPPER:   ext_o = upper_ext;
      MODE_ILLEGAL: err_o = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: immediate extender behind a 2-entry registered skid buffer.
// Optional transfer counters via IMM_EXT_PIPE_STATS_EN. Revision 1.0.
`default_nettype none

module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  in_imm_i,
  input  logic [1:0]       in_mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_err_o
`ifdef IMM_EXT_PIPE_STATS_EN
  ,
  output logic [31:0]      stat_beats_o,
  output logic [31:0]      stat_errs_o
`endif
);

  skid_state_e      state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic             out_err_q;
  logic [OUT_W-1:0] skid_data_q;
  logic             skid_err_q;

  logic [OUT_W-1:0] ext_d;
  logic             ext_err_d;
  logic             in_xfer;
  logic             out_xfer;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm_i  (in_imm_i),
    .mode_i (in_mode_i),
    .ext_o  (ext_d),
    .err_o  (ext_err_d)
  );

  assign in_xfer  = in_valid_i && in_ready_q;
  assign out_xfer = out_valid_q && out_ready_i;

  // in_ready is set from the state being entered, so it never depends on out_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      in_ready_q <= 1'b1;
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            out_data_q  <= ext_d;
            out_err_q   <= ext_err_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            out_data_q <= ext_d;
            out_err_q  <= ext_err_d;
          end else if (in_xfer) begin
            skid_data_q <= ext_d;
            skid_err_q  <= ext_err_d;
            state_q     <= ST_TWO;
            in_ready_q  <= 1'b0;
          end else if (out_xfer) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            out_data_q <= skid_data_q;
            out_err_q  <= skid_err_q;
            state_q    <= ST_ONE;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_EMPTY;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_err_o   = out_err_q;

`ifdef IMM_EXT_PIPE_STATS_EN
  logic [31:0] stat_beats_q;
  logic [31:0] stat_errs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats_q <= '0;
      stat_errs_q  <= '0;
    end else if (out_xfer) begin
      stat_beats_q <= stat_beats_q + 32'd1;
      if (out_err_q) begin
        stat_errs_q <= stat_errs_q + 32'd1;
      end
    end
  end

  assign stat_beats_o = stat_beats_q;
  assign stat_errs_o  = stat_errs_q;
`endif

endmodule

`default_nettype wire

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 Parameter IN_W, default 16, width of the raw immediate field.
REQ-002 Parameter OUT_W, default 32, width of the extended result; OUT_W >= IN_W is required, else elaboration fails.
REQ-003 clk  input  1  single rising-edge clock.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  input beat present.
REQ-006 in_ready  output  1  block accepts the input beat this cycle.
REQ-007 in_imm  input  IN_W  raw immediate.
REQ-008 in_mode  input  2  00 sign-extend, 01 zero-extend, 10 upper-place, 11 illegal.
REQ-009 out_valid  output  1  result beat present.
REQ-010 out_ready  input  1  consumer accepts the result beat.
REQ-011 out_data  output  OUT_W  extended result.
REQ-012 out_err  output  1  result came from an illegal mode; qualified by out_valid.

Function
REQ-013 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-014 Sign mode: out_data = in_imm with bit IN_W-1 replicated into the upper OUT_W-IN_W bits.
REQ-015 Zero mode: out_data = in_imm with zeros in the upper bits.
REQ-016 Upper mode: out_data = in_imm << (OUT_W-IN_W), with zeros in the low bits; when OUT_W == IN_W this equals in_imm.
REQ-017 Illegal mode: out_data = 0 and out_err = 1; the beat is still transferred, never dropped.
REQ-018 The extension is computed combinationally at the input, and all outputs come from registers.
REQ-019 Latency is one cycle: a beat accepted at edge N is presented with out_valid at edge N, visible in cycle N+1.
REQ-020 Buffering is a 2-entry skid: output register plus skid register, with states EMPTY, ONE and TWO.
REQ-021 EMPTY to ONE on input transfer.
REQ-022 ONE stays in ONE on simultaneous input and output transfer; moves to TWO on input transfer only; moves to EMPTY on output transfer only.
REQ-023 TWO to ONE on output transfer, with the skid entry moving into the output register.
REQ-024 in_ready = (state != TWO) and is registered, with no combinational path from out_ready.
REQ-025 Throughput is one beat per cycle while out_ready is held high.
REQ-026 Beats leave in acceptance order; no beat is duplicated or lost under any valid/ready pattern.
REQ-027 out_data and out_err hold stable while out_valid && !out_ready.

Reset
REQ-028 While rst_n is low: state = EMPTY, out_valid = 0, in_ready = 0, out_data = 0, out_err = 0.
REQ-029 The first rising clk edge after rst_n deasserts sets in_ready = 1.
REQ-030 Reset asserted mid-operation discards all buffered beats immediately, without waiting for a clock.

Configuration
REQ-031 Macro IMM_EXT_PIPE_STATS_EN, when defined, adds outputs stat_beats (32 bit, count of output transfers) and stat_errs (32 bit, count of output transfers with out_err = 1).
REQ-032 Both counters reset to 0 and wrap from 32'hFFFFFFFF to 0 without saturating.
REQ-033 Without the macro the ports and counters are absent, and all other behaviour is identical.

Structure
REQ-034 The shared package imm_ext_pkg holds the mode encodings (MODE_SIGN, MODE_ZERO, MODE_UPPER, MODE_ILLEGAL) and the skid-state encoding.
REQ-035 The extension logic lives in sub-module imm_ext_core, which is purely combinational and parametrised by IN_W and OUT_W.
REQ-036 imm_ext_pipe instantiates imm_ext_core once and owns all registers.

Verification
REQ-037 The bench shall cover these directed scenarios, using the default parameters unless noted:
- Sign mode, 16'h1234 -> 32'h00001234; sign mode, 16'hFEDC -> 32'hFFFFFEDC, each presented one cycle after acceptance.
- Zero mode, 16'hFEDC -> 32'h0000FEDC; upper mode, 16'hFEDC -> 32'hFEDC0000; mode 11 with any value -> 32'h00000000 with out_err = 1.
- out_ready held low while three beats are offered: two accepted, in_ready falls; out_ready then raised, so both drain in order and the third is accepted; with STATS_EN, stat_beats = 3.
- Back-to-back streaming of 100 random beats with out_ready high: one beat per cycle, results match the model, in_ready never drops.
- rst_n pulsed low in state TWO: out_valid falls immediately and no stale beat appears after reset release.
- Parameters IN_W = 12, OUT_W = 16, sign mode, 12'h800 -> 16'hF800; upper mode, 12'h800 -> 16'h8000.
